// File: rtl/hunt_round_ctrl.sv
// Game-flow controller for the duck hunt: dog intro, multi-duck rounds, shot and
// bird bookkeeping, saturating score, and the frame-timed resolve phase.
module hunt_round_ctrl #(
    parameter int unsigned NUM_DUCKS       = 2,
    parameter int unsigned SHOTS_PER_ROUND = 3,
    parameter int unsigned BIRDS_PER_GAME  = 10,
    parameter int unsigned POINTS_PER_HIT  = 5,
    parameter int unsigned SCORE_W         = 16,
    parameter int unsigned DOG_FRAMES      = 60,
    localparam int unsigned SHOT_W         = $clog2(SHOTS_PER_ROUND + 1),
    localparam int unsigned BIRD_W         = $clog2(BIRDS_PER_GAME + 1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 frame_clk,
    input  logic                 shot,
    input  logic [NUM_DUCKS-1:0] duck_hit,
    input  logic [NUM_DUCKS-1:0] duck_gone,
    output logic [2:0]           state,
    output logic                 new_round,
    output logic [NUM_DUCKS-1:0] duck_active,
    output logic [NUM_DUCKS-1:0] hit_mask,
    output logic                 no_shots_left,
    output logic [SHOT_W-1:0]    shots_left,
    output logic [BIRD_W-1:0]    birds_left,
    output logic [SCORE_W-1:0]   score,
    output logic                 dog_start,
    output logic                 dog_duck,
    output logic                 dog_laugh,
    output logic                 game_over
);

    localparam int unsigned FRAME_W = $clog2(DOG_FRAMES + 1);
    localparam int unsigned SUM_W   = SCORE_W + 32;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(DOG_FRAMES - 1);
    localparam logic [SUM_W-1:0]   SCORE_MAX  = SUM_W'({SCORE_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INTRO     = 3'd1,
        S_LAUNCH    = 3'd2,
        S_PLAY      = 3'd3,
        S_RESOLVE   = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    state_t                 state_q;
    logic                   start_q, shot_q, frame_q;
    logic [FRAME_W-1:0]     frame_cnt_q;
    logic                   new_round_q, no_shots_left_q;
    logic [NUM_DUCKS-1:0]   duck_active_q, hit_mask_q;
    logic [SHOT_W-1:0]      shots_left_q;
    logic [BIRD_W-1:0]      birds_left_q;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic                   dog_start_q, dog_duck_q, dog_laugh_q, game_over_q;

    logic                   start_rise_c, shot_rise_c, frame_rise_c, shot_fire_c;
    logic [NUM_DUCKS-1:0]   hit_new_c, launch_mask_c;
    logic [2:0]             hit_cnt_c;
    logic [SUM_W-1:0]       score_sum_c;
    logic [31:0]            launch_n_c;

    assign start_rise_c = start & ~start_q;
    assign shot_rise_c  = shot & ~shot_q;
    assign frame_rise_c = frame_clk & ~frame_q;
    assign shot_fire_c  = shot_rise_c && (shots_left_q != '0);

    // New hits this shot, saturating score, and the launch mask for this round
    always_comb begin
        hit_new_c = duck_hit & duck_active_q & ~hit_mask_q;
        hit_cnt_c = '0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            hit_cnt_c = hit_cnt_c + 3'(hit_new_c[i]);
        end
        score_sum_c = SUM_W'(score_q) + SUM_W'(hit_cnt_c) * SUM_W'(POINTS_PER_HIT);
        score_d     = (score_sum_c > SCORE_MAX) ? '1 : score_sum_c[SCORE_W-1:0];

        launch_n_c    = (32'(birds_left_q) < NUM_DUCKS) ? 32'(birds_left_q) : 32'(NUM_DUCKS);
        launch_mask_c = '0;
        for (int i = 0; i < NUM_DUCKS; i++) begin
            launch_mask_c[i] = (32'(i) < launch_n_c);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q         <= S_IDLE;
            start_q         <= 1'b0;
            shot_q          <= 1'b0;
            frame_q         <= 1'b0;
            frame_cnt_q     <= '0;
            new_round_q     <= 1'b0;
            no_shots_left_q <= 1'b0;
            duck_active_q   <= '0;
            hit_mask_q      <= '0;
            shots_left_q    <= '0;
            birds_left_q    <= '0;
            score_q         <= '0;
            dog_start_q     <= 1'b0;
            dog_duck_q      <= 1'b0;
            dog_laugh_q     <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            start_q     <= start;
            shot_q      <= shot;
            frame_q     <= frame_clk;
            new_round_q <= 1'b0;
            case (state_q)
                S_IDLE, S_GAME_OVER: begin
                    if (start_rise_c) begin
                        score_q      <= '0;
                        birds_left_q <= BIRD_W'(BIRDS_PER_GAME);
                        frame_cnt_q  <= '0;
                        dog_start_q  <= 1'b1;
                        game_over_q  <= 1'b0;
                        state_q      <= S_INTRO;
                    end
                end
                S_INTRO: begin
                    if (frame_rise_c) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            dog_start_q <= 1'b0;
                            new_round_q <= 1'b1;
                            state_q     <= S_LAUNCH;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                        end
                    end
                end
                S_LAUNCH: begin
                    duck_active_q   <= launch_mask_c;
                    birds_left_q    <= birds_left_q - BIRD_W'(launch_n_c);
                    shots_left_q    <= SHOT_W'(SHOTS_PER_ROUND);
                    hit_mask_q      <= '0;
                    no_shots_left_q <= (SHOTS_PER_ROUND == 0);
                    state_q         <= S_PLAY;
                end
                S_PLAY: begin
                    if (shot_fire_c) begin
                        shots_left_q    <= shots_left_q - SHOT_W'(1);
                        hit_mask_q      <= hit_mask_q | hit_new_c;
                        score_q         <= score_d;
                        no_shots_left_q <= (shots_left_q == SHOT_W'(1));
                    end
                    // Hits above use the pre-clear active set, so hit+gone counts the hit
                    duck_active_q <= duck_active_q & ~duck_gone;
                    if (duck_active_q == '0) begin
                        frame_cnt_q     <= '0;
                        no_shots_left_q <= 1'b0;
                        dog_duck_q      <= (hit_mask_q != '0);
                        dog_laugh_q     <= (hit_mask_q == '0);
                        state_q         <= S_RESOLVE;
                    end
                end
                S_RESOLVE: begin
                    if (frame_rise_c) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            dog_duck_q  <= 1'b0;
                            dog_laugh_q <= 1'b0;
                            if (birds_left_q != '0) begin
                                new_round_q <= 1'b1;
                                state_q     <= S_LAUNCH;
                            end else begin
                                game_over_q <= 1'b1;
                                state_q     <= S_GAME_OVER;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state         = state_q;
    assign new_round     = new_round_q;
    assign duck_active   = duck_active_q;
    assign hit_mask      = hit_mask_q;
    assign no_shots_left = no_shots_left_q;
    assign shots_left    = shots_left_q;
    assign birds_left    = birds_left_q;
    assign score         = score_q;
    assign dog_start     = dog_start_q;
    assign dog_duck      = dog_duck_q;
    assign dog_laugh     = dog_laugh_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_hunt_round_ctrl.sv
// Bench for hunt_round_ctrl: three instances (defaults, 3 birds, 4-bit score) share
// one stimulus stream; shot results go through a scoreboard queue.
module tb_hunt_round_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0, frame_clk = 1'b0, shot = 1'b0;
    logic [1:0] duck_hit = 2'b00, duck_gone = 2'b00;

    logic [2:0]  st_a, st_b, st_c;
    logic        nr_a, nr_b, nr_c, ns_a, ns_b, ns_c;
    logic [1:0]  act_a, act_b, act_c, hm_a, hm_b, hm_c;
    logic [1:0]  sh_a, sh_b, sh_c;
    logic [3:0]  bl_a, bl_c;
    logic [1:0]  bl_b;
    logic [15:0] sc_a, sc_b;
    logic [3:0]  sc_c;
    logic        ds_a, ds_b, ds_c, dd_a, dd_b, dd_c, dl_a, dl_b, dl_c, go_a, go_b, go_c;

    hunt_round_ctrl #(.DOG_FRAMES(4)) u_a (
        .Clk(Clk), .Reset(Reset), .start(start), .frame_clk(frame_clk), .shot(shot),
        .duck_hit(duck_hit), .duck_gone(duck_gone), .state(st_a), .new_round(nr_a),
        .duck_active(act_a), .hit_mask(hm_a), .no_shots_left(ns_a), .shots_left(sh_a),
        .birds_left(bl_a), .score(sc_a), .dog_start(ds_a), .dog_duck(dd_a),
        .dog_laugh(dl_a), .game_over(go_a));

    hunt_round_ctrl #(.DOG_FRAMES(4), .BIRDS_PER_GAME(3)) u_b (
        .Clk(Clk), .Reset(Reset), .start(start), .frame_clk(frame_clk), .shot(shot),
        .duck_hit(duck_hit), .duck_gone(duck_gone), .state(st_b), .new_round(nr_b),
        .duck_active(act_b), .hit_mask(hm_b), .no_shots_left(ns_b), .shots_left(sh_b),
        .birds_left(bl_b), .score(sc_b), .dog_start(ds_b), .dog_duck(dd_b),
        .dog_laugh(dl_b), .game_over(go_b));

    hunt_round_ctrl #(.DOG_FRAMES(4), .SCORE_W(4)) u_c (
        .Clk(Clk), .Reset(Reset), .start(start), .frame_clk(frame_clk), .shot(shot),
        .duck_hit(duck_hit), .duck_gone(duck_gone), .state(st_c), .new_round(nr_c),
        .duck_active(act_c), .hit_mask(hm_c), .no_shots_left(ns_c), .shots_left(sh_c),
        .birds_left(bl_c), .score(sc_c), .dog_start(ds_c), .dog_duck(dd_c),
        .dog_laugh(dl_c), .game_over(go_c));

    always #5 Clk = ~Clk;

    typedef struct {
        int         score_a;
        int         score_c;
        int         shots;
        logic [1:0] hit;
        logic [1:0] active;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   nr_cnt_a = 0;
    int   nr_cnt_c = 0;

    // Reference model of the round for instances a and c
    int         m_score_a, m_score_c, m_shots;
    logic [1:0] m_hit, m_active;

    always @(negedge Clk) begin
        if (nr_a === 1'b1) nr_cnt_a++;
        if (nr_c === 1'b1) nr_cnt_c++;
    end

    task automatic ftick();
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic model_launch();
        m_active = 2'b11;
        m_shots  = 3;
        m_hit    = 2'b00;
    endtask

    task automatic drive_shot(input logic [1:0] hit, input logic [1:0] gone);
        exp_t       e;
        logic [1:0] h;
        int         pts;
        if (m_shots > 0) begin
            m_shots--;
            h     = hit & m_active & ~m_hit;
            m_hit = m_hit | h;
            pts   = (int'(h[0]) + int'(h[1])) * 5;
            m_score_a = (m_score_a + pts > 65535) ? 65535 : m_score_a + pts;
            m_score_c = (m_score_c + pts > 15) ? 15 : m_score_c + pts;
        end
        m_active = m_active & ~gone;
        e = '{m_score_a, m_score_c, m_shots, m_hit, m_active};
        sb.push_back(e);
        duck_hit  = hit;
        duck_gone = gone;
        shot      = 1'b1;
        @(negedge Clk);
        shot      = 1'b0;
        duck_hit  = 2'b00;
        duck_gone = 2'b00;
        @(negedge Clk);
    endtask

    task automatic gone_pulse(input logic [1:0] g);
        duck_gone = g;
        m_active  = m_active & ~g;
        @(negedge Clk);
        duck_gone = 2'b00;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        n_tests++;
        if (st_a !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", st_a); end
        n_tests++;
        if ({sc_a, sh_a, bl_a, act_a, hm_a} !== '0) begin
            n_fail++; $display("FAIL reset_regs: score=%0d shots=%0d birds=%0d act=%b hit=%b expected all 0",
                               sc_a, sh_a, bl_a, act_a, hm_a);
        end
        n_tests++;
        if ({nr_a, ns_a, ds_a, dd_a, dl_a, go_a} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {nr_a, ns_a, ds_a, dd_a, dl_a, go_a});
        end
    endtask

    task automatic test_launch();
        int nr0;
        nr0 = nr_cnt_a;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        n_tests++;
        if (st_a !== 3'd1 || ds_a !== 1'b1) begin
            n_fail++; $display("FAIL intro_entry: state=%0d dog_start=%b expected 1/1", st_a, ds_a);
        end
        repeat (3) ftick();
        n_tests++;
        if (st_a !== 3'd1) begin n_fail++; $display("FAIL intro_hold: got %0d expected 1", st_a); end
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        n_tests++;
        if (st_a !== 3'd2 || nr_a !== 1'b1) begin
            n_fail++; $display("FAIL launch_state: state=%0d new_round=%b expected 2/1", st_a, nr_a);
        end
        @(negedge Clk);
        n_tests++;
        if (st_a !== 3'd3 || act_a !== 2'b11 || sh_a !== 2'd3 || bl_a !== 4'd8) begin
            n_fail++; $display("FAIL play_entry: state=%0d act=%b shots=%0d birds=%0d expected 3/11/3/8",
                               st_a, act_a, sh_a, bl_a);
        end
        @(negedge Clk);
        n_tests++;
        if (nr_cnt_a - nr0 !== 1) begin
            n_fail++; $display("FAIL new_round_pulse: got %0d cycles expected 1", nr_cnt_a - nr0);
        end
        m_score_a = 0;
        m_score_c = 0;
        model_launch();
    endtask

    task automatic test_hits();
        logic [1:0] hits [2] = '{2'b11, 2'b11};
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive_shot(hits[k], 2'b00);
            e = sb.pop_front();
            n_tests++;
            if (sc_a !== 16'(e.score_a) || hm_a !== e.hit || sh_a !== 2'(e.shots)) begin
                n_fail++; $display("FAIL hit_shot%0d: score=%0d hit=%b shots=%0d expected %0d/%b/%0d",
                                   k, sc_a, hm_a, sh_a, e.score_a, e.hit, e.shots);
            end
        end
        gone_pulse(2'b11);
        @(negedge Clk);
        n_tests++;
        if (st_a !== 3'd4 || dd_a !== 1'b1 || dl_a !== 1'b0) begin
            n_fail++; $display("FAIL resolve_duck: state=%0d dog_duck=%b dog_laugh=%b expected 4/1/0", st_a, dd_a, dl_a);
        end
        repeat (4) ftick();
        n_tests++;
        if (st_a !== 3'd3 || act_a !== 2'b11 || bl_a !== 4'd6 || sh_a !== 2'd3) begin
            n_fail++; $display("FAIL relaunch: state=%0d act=%b birds=%0d shots=%0d expected 3/11/6/3",
                               st_a, act_a, bl_a, sh_a);
        end
        model_launch();
    endtask

    task automatic test_last_round();
        n_tests++;
        if (act_b !== 2'b01 || bl_b !== 2'd0 || st_b !== 3'd3) begin
            n_fail++; $display("FAIL last_launch: act=%b birds=%0d state=%0d expected 01/0/3", act_b, bl_b, st_b);
        end
    endtask

    task automatic test_miss();
        logic [1:0] hits [4] = '{2'b00, 2'b00, 2'b00, 2'b11};
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            drive_shot(hits[k], 2'b00);
            e = sb.pop_front();
            n_tests++;
            if (sc_a !== 16'(e.score_a) || hm_a !== e.hit || sh_a !== 2'(e.shots)) begin
                n_fail++; $display("FAIL miss_shot%0d: score=%0d hit=%b shots=%0d expected %0d/%b/%0d",
                                   k, sc_a, hm_a, sh_a, e.score_a, e.hit, e.shots);
            end
        end
        n_tests++;
        if (ns_a !== 1'b1) begin n_fail++; $display("FAIL no_shots_left: got %b expected 1", ns_a); end
        gone_pulse(2'b11);
        @(negedge Clk);
        n_tests++;
        if (st_a !== 3'd4 || dl_a !== 1'b1 || dd_a !== 1'b0 || sc_a !== 16'd10) begin
            n_fail++; $display("FAIL resolve_laugh: state=%0d laugh=%b duck=%b score=%0d expected 4/1/0/10",
                               st_a, dl_a, dd_a, sc_a);
        end
        repeat (4) ftick();
        model_launch();
    endtask

    task automatic test_game_over();
        n_tests++;
        if (st_b !== 3'd5 || go_b !== 1'b1) begin
            n_fail++; $display("FAIL game_over: state=%0d game_over=%b expected 5/1", st_b, go_b);
        end
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        n_tests++;
        if (st_b !== 3'd1 || sc_b !== 16'd0 || go_b !== 1'b0) begin
            n_fail++; $display("FAIL restart: state=%0d score=%0d game_over=%b expected 1/0/0", st_b, sc_b, go_b);
        end
        n_tests++;
        if (st_a !== 3'd3) begin n_fail++; $display("FAIL start_in_play: state=%0d expected 3", st_a); end
        @(negedge Clk);
    endtask

    task automatic test_saturate();
        logic [1:0] hits  [2] = '{2'b01, 2'b10};
        logic [1:0] gones [2] = '{2'b01, 2'b00};
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            drive_shot(hits[k], gones[k]);
            e = sb.pop_front();
            n_tests++;
            if (sc_c !== 4'(e.score_c) || sc_a !== 16'(e.score_a)) begin
                n_fail++; $display("FAIL sat_score%0d: c=%0d a=%0d expected %0d/%0d",
                                   k, sc_c, sc_a, e.score_c, e.score_a);
            end
            n_tests++;
            if (act_c !== e.active || hm_c !== e.hit || sh_c !== 2'(e.shots)) begin
                n_fail++; $display("FAIL sat_state%0d: act=%b hit=%b shots=%0d expected %b/%b/%0d",
                                   k, act_c, hm_c, sh_c, e.active, e.hit, e.shots);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        int nr0;
        nr0 = nr_cnt_c;
        #2 Reset = 1'b1;
        #1;
        n_tests++;
        if (st_c !== 3'd0 || sc_c !== 4'd0 || act_c !== 2'b00 || st_a !== 3'd0) begin
            n_fail++; $display("FAIL async_reset: state=%0d score=%0d act=%b state_a=%0d expected 0/0/00/0",
                               st_c, sc_c, act_c, st_a);
        end
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_tests++;
        if (st_c !== 3'd0 || nr_cnt_c !== nr0) begin
            n_fail++; $display("FAIL post_reset: state=%0d new_round pulses=%0d expected 0/0", st_c, nr_cnt_c - nr0);
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_hits();
        test_last_round();
        test_miss();
        test_game_over();
        test_saturate();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
